// File: rtl/bpsk_modulator.sv
// bpsk_modulator: serial bit stream to BPSK carrier samples.
// Bits arrive over a valid/ready handshake. Each bit sets the carrier phase to
// 0 or pi for SAMPLES_PER_SYMBOL samples. Samples are paced by sample_en.
// A one-entry lookahead buffer lets consecutive symbols follow without a gap.
// Optional macro BPSK_DIFFERENTIAL_EN enables differential encoding.
// With the macro defined, tx = prev_tx ^ data at each symbol start.
module bpsk_modulator #(
    parameter int SAMPLE_WIDTH       = 8,
    parameter int PHASE_BITS         = 4,
    parameter int PHASE_STEP         = 1,
    parameter int SAMPLES_PER_SYMBOL = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_en,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid,
    output logic                           busy
);

    localparam int  N       = 1 << PHASE_BITS;
    localparam int  AMP_MAX = (1 << (SAMPLE_WIDTH - 1)) - 1;
    localparam int  CNT_W   = $clog2(SAMPLES_PER_SYMBOL);
    localparam real PI      = 3.14159265358979323846;

    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [PHASE_BITS-1:0] STEP     = PHASE_BITS'(PHASE_STEP % N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Sine table entry, evaluated at elaboration only. The angle is folded
    // into [-pi, pi] so a short Taylor series is exact to well below one LSB.
    // Rounding is half away from zero. The result is clamped to
    // +/-AMP_MAX, so negating an entry can never overflow.
    function automatic logic signed [SAMPLE_WIDTH-1:0] lutEntry(input int k);
        real ang;
        real x2;
        real term;
        real sum;
        real scaled;
        int  v;
        ang = 2.0 * PI * real'(k) / real'(N);
        if (ang > PI) begin
            ang = ang - 2.0 * PI;
        end
        x2   = ang * ang;
        term = ang;
        sum  = ang;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x2 / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scaled = real'(AMP_MAX) * sum;
        if (scaled >= 0.0) begin
            v = $rtoi(scaled + 0.5);
        end else begin
            v = -$rtoi(0.5 - scaled);
        end
        if (v > AMP_MAX) begin
            v = AMP_MAX;
        end
        if (v < -AMP_MAX) begin
            v = -AMP_MAX;
        end
        return SAMPLE_WIDTH'(v);
    endfunction

    logic signed [SAMPLE_WIDTH-1:0] w_lut [N];

    for (genvar k = 0; k < N; k++) begin : g_lut
        localparam logic signed [SAMPLE_WIDTH-1:0] LUT_K = lutEntry(k);
        assign w_lut[k] = LUT_K;
    end

    state_t                         r_state;
    logic [PHASE_BITS-1:0]          r_phase;
    logic [CNT_W-1:0]               r_symCnt;
    logic                           r_curBit;
    logic                           r_nextBit;
    logic                           r_nextFull;
    logic signed [SAMPLE_WIDTH-1:0] r_sampleOut;
    logic                           r_sampleValid;

    state_t                         w_stateNext;
    logic [PHASE_BITS-1:0]          w_phaseNext;
    logic [CNT_W-1:0]               w_symCntNext;
    logic                           w_curBitNext;
    logic                           w_nextBitNext;
    logic                           w_nextFullNext;
    logic signed [SAMPLE_WIDTH-1:0] w_sampleOutNext;
    logic                           w_sampleValidNext;

    logic                           w_xfer;
    logic                           w_txFromIn;
    logic                           w_txFromBuf;
    logic signed [SAMPLE_WIDTH-1:0] w_lutVal;

    assign w_xfer   = bit_valid && !r_nextFull;
    assign w_lutVal = w_lut[r_phase];

`ifdef BPSK_DIFFERENTIAL_EN
    logic r_prevTx;
    logic w_prevTxNext;

    assign w_txFromIn  = r_prevTx ^ bit_in;
    assign w_txFromBuf = r_prevTx ^ r_nextBit;

    // The previous transmitted bit, held for differential encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prevTx <= 1'b0;
        end else begin
            r_prevTx <= w_prevTxNext;
        end
    end
`else
    assign w_txFromIn  = bit_in;
    assign w_txFromBuf = r_nextBit;
`endif

    // State and datapath registers. rst clears them to the idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_symCnt      <= '0;
            r_curBit      <= 1'b0;
            r_nextBit     <= 1'b0;
            r_nextFull    <= 1'b0;
            r_sampleOut   <= '0;
            r_sampleValid <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_phase       <= w_phaseNext;
            r_symCnt      <= w_symCntNext;
            r_curBit      <= w_curBitNext;
            r_nextBit     <= w_nextBitNext;
            r_nextFull    <= w_nextFullNext;
            r_sampleOut   <= w_sampleOutNext;
            r_sampleValid <= w_sampleValidNext;
        end
    end

    // Next-state logic covers the handshake, sample generation and the symbol
    // boundary. At a boundary the buffered bit is used first. If the buffer is
    // empty, a bit arriving that cycle is used instead. With neither, the
    // block returns to IDLE.
    always_comb begin
        w_stateNext       = r_state;
        w_phaseNext       = r_phase;
        w_symCntNext      = r_symCnt;
        w_curBitNext      = r_curBit;
        w_nextBitNext     = r_nextBit;
        w_nextFullNext    = r_nextFull;
        w_sampleOutNext   = r_sampleOut;
        w_sampleValidNext = sample_en;
`ifdef BPSK_DIFFERENTIAL_EN
        w_prevTxNext      = r_prevTx;
`endif
        case (r_state)
            ST_IDLE: begin
                if (sample_en) begin
                    w_sampleOutNext = '0;
                end
                if (w_xfer) begin
                    w_stateNext  = ST_ACTIVE;
                    w_curBitNext = w_txFromIn;
                    w_phaseNext  = '0;
                    w_symCntNext = '0;
`ifdef BPSK_DIFFERENTIAL_EN
                    w_prevTxNext = w_txFromIn;
`endif
                end
            end
            ST_ACTIVE: begin
                if (w_xfer) begin
                    w_nextBitNext  = bit_in;
                    w_nextFullNext = 1'b1;
                end
                if (sample_en) begin
                    w_sampleOutNext = r_curBit ? -w_lutVal : w_lutVal;
                    w_phaseNext     = r_phase + STEP;
                    w_symCntNext    = r_symCnt + CNT_W'(1);
                    if (r_symCnt == LAST_CNT) begin
                        w_symCntNext = '0;
                        if (r_nextFull) begin
                            w_curBitNext   = w_txFromBuf;
                            w_nextFullNext = 1'b0;
`ifdef BPSK_DIFFERENTIAL_EN
                            w_prevTxNext   = w_txFromBuf;
`endif
                        end else if (w_xfer) begin
                            w_curBitNext   = w_txFromIn;
                            w_nextFullNext = 1'b0;
`ifdef BPSK_DIFFERENTIAL_EN
                            w_prevTxNext   = w_txFromIn;
`endif
                        end else begin
                            w_stateNext = ST_IDLE;
                            w_phaseNext = '0;
`ifdef BPSK_DIFFERENTIAL_EN
                            w_prevTxNext = 1'b0;
`endif
                        end
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign bit_ready    = !r_nextFull;
    assign busy         = (r_state == ST_ACTIVE);
    assign sample_out   = r_sampleOut;
    assign sample_valid = r_sampleValid;

endmodule

// File: tb/tb_bpsk_modulator.sv
// tb_bpsk_modulator: scoreboard bench for bpsk_modulator (default parameters).
// Stimulus queues the hand-computed sample expected for each sample_en.
// A monitor pops and compares on every sample_valid pulse.
module tb_bpsk_modulator;

    logic              clk;
    logic              rst;
    logic              sample_en;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic              busy;

    int total;
    int bad;

    logic signed [7:0] expQ [$];
    logic signed [7:0] monExp;

    // One carrier period for a 0 bit: round(127*sin(2*pi*k/16)).
    logic signed [7:0] posTable [16] = '{
        8'sd0, 8'sd49, 8'sd90, 8'sd117, 8'sd127, 8'sd117, 8'sd90, 8'sd49,
        8'sd0, -8'sd49, -8'sd90, -8'sd117, -8'sd127, -8'sd117, -8'sd90, -8'sd49
    };

    bpsk_modulator dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 200000ns");
        $fatal(1, "[TB] timeout");
    end

    // Monitor: compare each presented sample against the oldest expectation
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL sample_unexpected: got %0d, required no sample", sample_out);
            end else begin
                monExp = expQ.pop_front();
                if (sample_out !== monExp) begin
                    bad++;
                    $display("[TB] FAIL sample: got %0d, required %0d", sample_out, monExp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Drive one clock cycle of inputs. Queue the expected sample if sample_en
    // is set. Report whether a handshake transfer happens at this edge.
    task automatic applyStimulus(input logic en, input logic v, input logic b,
                                 input logic signed [7:0] expSample, output logic xfer);
        sample_en = en;
        bit_valid = v;
        bit_in    = b;
        if (en) begin
            expQ.push_back(expSample);
        end
        xfer = v && bit_ready;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        bit_valid = 1'b0;
    endtask

    // Send one isolated bit and emit its 16 samples, sample_en every 4 clocks.
    // Then confirm return to IDLE and a zero sample.
    task automatic sendSingle(input logic b, input string tag);
        logic x;
        applyStimulus(1'b0, 1'b1, b, 8'sd0, x);
        checkOutput({tag, "_accept"}, int'(x), 1);
        checkOutput({tag, "_busy_on"}, int'(busy), 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, b ? -posTable[i] : posTable[i], x);
            repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        end
        checkOutput({tag, "_busy_off"}, int'(busy), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'sd0, x);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        checkOutput({tag, "_idle_zero"}, int'(sample_out), 0);
    endtask

    // Stream three bits with bit_valid held until all three are accepted.
    // Emit 48 samples with sample_en every other clock. neg[i] gives the
    // expected carrier sign of symbol i.
    task automatic runStream(input logic [2:0] bits, input logic [2:0] neg, input string tag);
        logic x;
        logic bv;
        int   idx;
        int   sym;
        logic signed [7:0] e;
        idx = 0;
        applyStimulus(1'b0, 1'b1, bits[0], 8'sd0, x);
        if (x) idx++;
        checkOutput({tag, "_accept0"}, int'(x), 1);
        for (int s = 0; s < 48; s++) begin
            sym = s / 16;
            e   = neg[sym] ? -posTable[s % 16] : posTable[s % 16];
            for (int ph = 0; ph < 2; ph++) begin
                bv = 1'b0;
                if (idx < 3) bv = bits[idx];
                applyStimulus(ph == 0, idx < 3, bv, e, x);
                if (x) begin
                    idx++;
                    if (idx == 2) begin
                        checkOutput({tag, "_ready_full"}, int'(bit_ready), 0);
                    end
                end
            end
        end
        checkOutput({tag, "_all_accepted"}, idx, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        checkOutput({tag, "_busy_off"}, int'(busy), 0);
        checkOutput({tag, "_ready_end"}, int'(bit_ready), 1);
    endtask

    // Main directed sequence
    initial begin
        logic x;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        sample_en = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_sample_out", int'(sample_out), 0);
        checkOutput("reset_sample_valid", int'(sample_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_bit_ready", int'(bit_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] idle samples");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'sd0, x);
            applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        end
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_bit_ready", int'(bit_ready), 1);

        $display("[TB] single bit 0");
        sendSingle(1'b0, "bit0");
        $display("[TB] single bit 1");
        sendSingle(1'b1, "bit1");

        $display("[TB] stream 0,1,1");
`ifdef BPSK_DIFFERENTIAL_EN
        runStream(3'b110, 3'b010, "stream011");
`else
        runStream(3'b110, 3'b110, "stream011");
`endif

        $display("[TB] reset mid-symbol");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'sd0, x);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, posTable[i], x);
            applyStimulus(1'b0, i == 2, 1'b1, 8'sd0, x);
        end
        checkOutput("pre_reset_ready", int'(bit_ready), 0);
        checkOutput("pre_reset_busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_sample_out", int'(sample_out), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_bit_ready", int'(bit_ready), 1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'sd0, x);
        checkOutput("restart_accept", int'(x), 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, posTable[i], x);
            applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        end
        checkOutput("restart_busy_off", int'(busy), 0);

        $display("[TB] stream 1,1,0");
`ifdef BPSK_DIFFERENTIAL_EN
        runStream(3'b011, 3'b001, "stream110");
`else
        runStream(3'b011, 3'b011, "stream110");
`endif

        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'sd0, x);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
